// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// hazard or flush, and saturating bubble counters for performance debug.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_jtopc,
  input  logic              id_branch,
  input  logic              id_regwrite,
  input  logic              id_regdst,
  input  logic              id_alusrc,
  input  logic              id_memwrite,
  input  logic              id_memread,
  input  logic              id_memtoreg,
  input  logic [3:0]        id_aluop,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              flush,
  output logic              ex_jtopc,
  output logic              ex_branch,
  output logic              ex_regwrite,
  output logic              ex_regdst,
  output logic              ex_alusrc,
  output logic              ex_memwrite,
  output logic              ex_memread,
  output logic              ex_memtoreg,
  output logic [3:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              stall,
  output logic [CNT_W-1:0]  hazard_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic rt_used_s;
  logic hazard_s;

  // Load-use detection: the load in EX writes a register the decode instruction reads.
  always_comb begin
    rt_used_s = id_regdst | id_memwrite | id_branch;
    hazard_s  = 1'b0;
    stall     = 1'b0;
    if (ex_memread && (ex_rt != 5'd0) &&
        ((ex_rt == id_rs) || (rt_used_s && (ex_rt == id_rt)))) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
    // A squashed instruction must not hold upstream; reset also forces release.
    if (hazard_s && !flush && !reset) begin
      stall = 1'b1;
    end else begin
      stall = 1'b0;
    end
  end

  // Pipeline register: reset, bubble on flush/hazard, otherwise capture decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_jtopc    <= 1'b0;
      ex_branch   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_regdst   <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_aluop    <= 4'b0000;
      ex_rdata1   <= {DATA_W{1'b0}};
      ex_rdata2   <= {DATA_W{1'b0}};
      ex_imm      <= {DATA_W{1'b0}};
      ex_pc4      <= {DATA_W{1'b0}};
      ex_rs       <= 5'd0;
      ex_rt       <= 5'd0;
      ex_rd       <= 5'd0;
      hazard_cnt  <= {CNT_W{1'b0}};
      flush_cnt   <= {CNT_W{1'b0}};
    end else if (flush || hazard_s) begin
      // Bubble data is zeroed too so nothing downstream forwards from it.
      ex_jtopc    <= 1'b0;
      ex_branch   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_regdst   <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_aluop    <= 4'b0000;
      ex_rdata1   <= {DATA_W{1'b0}};
      ex_rdata2   <= {DATA_W{1'b0}};
      ex_imm      <= {DATA_W{1'b0}};
      ex_pc4      <= {DATA_W{1'b0}};
      ex_rs       <= 5'd0;
      ex_rt       <= 5'd0;
      ex_rd       <= 5'd0;
      if (flush) begin
        if (flush_cnt != CNT_MAX) begin
          flush_cnt <= flush_cnt + CNT_ONE;
        end else begin
          flush_cnt <= flush_cnt;
        end
      end else begin
        if (hazard_cnt != CNT_MAX) begin
          hazard_cnt <= hazard_cnt + CNT_ONE;
        end else begin
          hazard_cnt <= hazard_cnt;
        end
      end
    end else begin
      ex_jtopc    <= id_jtopc;
      ex_branch   <= id_branch;
      ex_regwrite <= id_regwrite;
      ex_regdst   <= id_regdst;
      ex_alusrc   <= id_alusrc;
      ex_memwrite <= id_memwrite;
      ex_memread  <= id_memread;
      ex_memtoreg <= id_memtoreg;
      ex_aluop    <= id_aluop;
      ex_rdata1   <= id_rdata1;
      ex_rdata2   <= id_rdata2;
      ex_imm      <= id_imm;
      ex_pc4      <= id_pc4;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with 2-bit counters
// exercises counter saturation in a short run.
module tb_id_ex_stage;
  logic        clk;
  logic        reset;
  logic        id_jtopc, id_branch, id_regwrite, id_regdst;
  logic        id_alusrc, id_memwrite, id_memread, id_memtoreg;
  logic [3:0]  id_aluop;
  logic [31:0] id_rdata1, id_rdata2, id_imm, id_pc4;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        flush;

  logic        ex_jtopc, ex_branch, ex_regwrite, ex_regdst;
  logic        ex_alusrc, ex_memwrite, ex_memread, ex_memtoreg;
  logic [3:0]  ex_aluop;
  logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        stall;
  logic [15:0] hazard_cnt, flush_cnt;

  logic        s_jtopc, s_branch, s_regwrite, s_regdst;
  logic        s_alusrc, s_memwrite, s_memread, s_memtoreg;
  logic [3:0]  s_aluop;
  logic [31:0] s_rdata1, s_rdata2, s_imm, s_pc4;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic        s_stall;
  logic [1:0]  s_hazard_cnt, s_flush_cnt;

  int checks = 0;
  int failures = 0;

  wire [154:0] ex_all = {ex_jtopc, ex_branch, ex_regwrite, ex_regdst, ex_alusrc,
                         ex_memwrite, ex_memread, ex_memtoreg, ex_aluop, ex_rdata1,
                         ex_rdata2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd};

  id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_jtopc(id_jtopc), .id_branch(id_branch), .id_regwrite(id_regwrite),
    .id_regdst(id_regdst), .id_alusrc(id_alusrc), .id_memwrite(id_memwrite),
    .id_memread(id_memread), .id_memtoreg(id_memtoreg), .id_aluop(id_aluop),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .ex_jtopc(ex_jtopc), .ex_branch(ex_branch), .ex_regwrite(ex_regwrite),
    .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_memwrite(ex_memwrite),
    .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg), .ex_aluop(ex_aluop),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .stall(stall),
    .hazard_cnt(hazard_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .id_jtopc(id_jtopc), .id_branch(id_branch), .id_regwrite(id_regwrite),
    .id_regdst(id_regdst), .id_alusrc(id_alusrc), .id_memwrite(id_memwrite),
    .id_memread(id_memread), .id_memtoreg(id_memtoreg), .id_aluop(id_aluop),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .ex_jtopc(s_jtopc), .ex_branch(s_branch), .ex_regwrite(s_regwrite),
    .ex_regdst(s_regdst), .ex_alusrc(s_alusrc), .ex_memwrite(s_memwrite),
    .ex_memread(s_memread), .ex_memtoreg(s_memtoreg), .ex_aluop(s_aluop),
    .ex_rdata1(s_rdata1), .ex_rdata2(s_rdata2), .ex_imm(s_imm), .ex_pc4(s_pc4),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .stall(s_stall),
    .hazard_cnt(s_hazard_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    {id_jtopc, id_branch, id_regwrite, id_regdst} = 4'b0000;
    {id_alusrc, id_memwrite, id_memread, id_memtoreg} = 4'b0000;
    id_aluop = 4'b0000;
    id_rdata1 = 32'd0; id_rdata2 = 32'd0; id_imm = 32'd0; id_pc4 = 32'd0;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
    flush = 1'b0;
    #1;
  endtask

  // lw r<rt>, imm(r<rs>)
  task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
    set_nop();
    id_regwrite = 1'b1; id_alusrc = 1'b1; id_memread = 1'b1; id_memtoreg = 1'b1;
    id_aluop = 4'b0001; id_rs = rs; id_rt = rt; id_imm = 32'h10; id_pc4 = 32'h104;
    #1;
  endtask

  // add r3, r<rs>, r<rt>
  task automatic set_add(input logic [4:0] rs, input logic [4:0] rt);
    set_nop();
    id_regwrite = 1'b1; id_regdst = 1'b1; id_aluop = 4'b0001;
    id_rs = rs; id_rt = rt; id_rd = 5'd3; id_rdata1 = 32'd5; id_rdata2 = 32'd7;
    id_pc4 = 32'h108;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {id_jtopc, id_branch, id_regwrite, id_regdst} = 4'b1111;
    {id_alusrc, id_memwrite, id_memread, id_memtoreg} = 4'b1111;
    id_aluop = 4'b1010; id_rdata1 = 32'hDEADBEEF; id_rdata2 = 32'h12345678;
    id_imm = 32'hFFFF0000; id_pc4 = 32'h400; id_rs = 5'd7; id_rt = 5'd7; id_rd = 5'd9;
    flush = 1'b1;
    step(); step();
    checks++;
    if (ex_all !== 155'd0) begin
      failures++; $display("FAIL reset_ex got=%h want=0", ex_all);
    end
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%b want=0", stall);
    end
    checks++;
    if (hazard_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_cnt got=%h/%h want=0/0", hazard_cnt, flush_cnt);
    end
    reset = 1'b0;
    set_nop();
    step();
  endtask

  task automatic test_passthrough();
    set_add(5'd1, 5'd2);
    id_imm = 32'hFFFFFFF0;
    step();
    checks++;
    if (ex_regwrite !== 1'b1 || ex_regdst !== 1'b1 || ex_memread !== 1'b0 ||
        ex_aluop !== 4'b0001) begin
      failures++; $display("FAIL add_ctrl got=%b%b%b/%b want=110/0001",
                           ex_regwrite, ex_regdst, ex_memread, ex_aluop);
    end
    checks++;
    if (ex_rdata1 !== 32'd5 || ex_rdata2 !== 32'd7 || ex_rd !== 5'd3 ||
        ex_rs !== 5'd1 || ex_rt !== 5'd2 || ex_imm !== 32'hFFFFFFF0 ||
        ex_pc4 !== 32'h108) begin
      failures++; $display("FAIL add_data got=%0d,%0d,rd%0d,rs%0d,rt%0d,%h,%h",
                           ex_rdata1, ex_rdata2, ex_rd, ex_rs, ex_rt, ex_imm, ex_pc4);
    end
    // Every control bit set, checks the remaining flags propagate.
    set_nop();
    {id_jtopc, id_branch, id_alusrc, id_memwrite} = 4'b1111;
    id_memtoreg = 1'b1; id_aluop = 4'b1100; id_rs = 5'd0; id_rt = 5'd0;
    step();
    checks++;
    if ({ex_jtopc, ex_branch, ex_alusrc, ex_memwrite, ex_memtoreg, ex_aluop} !== 9'b111111100) begin
      failures++; $display("FAIL ctrl_all got=%b want=111111100",
                           {ex_jtopc, ex_branch, ex_alusrc, ex_memwrite, ex_memtoreg, ex_aluop});
    end
    set_nop();
    step();
  endtask

  task automatic test_load_use();
    set_lw(5'd1, 5'd4);
    step();
    set_add(5'd4, 5'd2);
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL lu_stall got=%b want=1", stall);
    end
    step();
    checks++;
    if (ex_all !== 155'd0 || hazard_cnt !== 16'd1) begin
      failures++; $display("FAIL lu_bubble ex=%h hcnt=%0d want=0/1", ex_all, hazard_cnt);
    end
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL lu_release got=%b want=0", stall);
    end
    step();
    checks++;
    if (ex_rs !== 5'd4 || ex_regwrite !== 1'b1 || ex_rd !== 5'd3 || hazard_cnt !== 16'd1) begin
      failures++; $display("FAIL lu_issue rs=%0d rw=%b rd=%0d hcnt=%0d want=4/1/3/1",
                           ex_rs, ex_regwrite, ex_rd, hazard_cnt);
    end
    set_nop();
    step();
  endtask

  task automatic test_no_hazard();
    set_lw(5'd1, 5'd4);
    step();
    set_lw(5'd0, 5'd4);
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL nh_rt_unused got=%b want=0", stall);
    end
    step();
    checks++;
    if (ex_memread !== 1'b1 || ex_rt !== 5'd4 || hazard_cnt !== 16'd1) begin
      failures++; $display("FAIL nh_issue mr=%b rt=%0d hcnt=%0d want=1/4/1",
                           ex_memread, ex_rt, hazard_cnt);
    end
    set_lw(5'd1, 5'd0);
    step();
    set_add(5'd0, 5'd0);
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL nh_r0 got=%b want=0", stall);
    end
    // rt dependence counts when rt is a source (regdst=1).
    set_lw(5'd1, 5'd6);
    step();
    set_add(5'd2, 5'd6);
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL nh_rt_dep got=%b want=1", stall);
    end
    step();
    set_nop();
    step();
  endtask

  task automatic test_back_to_back();
    set_lw(5'd1, 5'd4);
    step();
    set_lw(5'd4, 5'd5);
    step();
    checks++;
    if (ex_memread !== 1'b0 || ex_rt !== 5'd0 || hazard_cnt !== 16'd3) begin
      failures++; $display("FAIL b2b_bubble mr=%b rt=%0d hcnt=%0d want=0/0/3",
                           ex_memread, ex_rt, hazard_cnt);
    end
    step();
    checks++;
    if (ex_memread !== 1'b1 || ex_rs !== 5'd4 || ex_rt !== 5'd5 || hazard_cnt !== 16'd3) begin
      failures++; $display("FAIL b2b_issue mr=%b rs=%0d rt=%0d hcnt=%0d want=1/4/5/3",
                           ex_memread, ex_rs, ex_rt, hazard_cnt);
    end
    set_nop();
    step();
  endtask

  task automatic test_flush_hazard();
    set_lw(5'd1, 5'd4);
    step();
    set_add(5'd4, 5'd2);
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL fl_stall got=%b want=0", stall);
    end
    step();
    checks++;
    if (ex_all !== 155'd0 || flush_cnt !== 16'd1 || hazard_cnt !== 16'd3) begin
      failures++; $display("FAIL fl_bubble ex=%h fcnt=%0d hcnt=%0d want=0/1/3",
                           ex_all, flush_cnt, hazard_cnt);
    end
    flush = 1'b0;
    step();
    checks++;
    if (ex_rs !== 5'd4 || ex_regwrite !== 1'b1 || flush_cnt !== 16'd1) begin
      failures++; $display("FAIL fl_after rs=%0d rw=%b fcnt=%0d want=4/1/1",
                           ex_rs, ex_regwrite, flush_cnt);
    end
    set_nop();
    step();
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_lw(5'd1, 5'd4);
      step();
      set_add(5'd4, 5'd2);
      step();
      step();
      if (i >= 2) begin
        checks++;
        if (s_hazard_cnt !== 2'b11) begin
          failures++; $display("FAIL sat_hold iter=%0d got=%b want=11", i, s_hazard_cnt);
        end
      end else if (i == 1) begin
        checks++;
        if (s_hazard_cnt !== 2'b10) begin
          failures++; $display("FAIL sat_pre got=%b want=10", s_hazard_cnt);
        end
      end
    end
    checks++;
    if (hazard_cnt !== 16'd5) begin
      failures++; $display("FAIL wide_cnt got=%0d want=5", hazard_cnt);
    end
    // Reset in the middle of a stall.
    set_lw(5'd1, 5'd4);
    step();
    set_add(5'd4, 5'd2);
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL mid_stall got=%b want=1", stall);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL rst_stall got=%b want=0", stall);
    end
    step();
    checks++;
    if (ex_all !== 155'd0 || hazard_cnt !== 16'd0 || s_hazard_cnt !== 2'b00 ||
        flush_cnt !== 16'd0) begin
      failures++; $display("FAIL rst_mid ex=%h hcnt=%0d scnt=%0d fcnt=%0d want=0",
                           ex_all, hazard_cnt, s_hazard_cnt, flush_cnt);
    end
    reset = 1'b0;
    set_nop();
    step();
  endtask

  initial begin
    reset = 1'b1;
    set_nop();
    test_reset();
    test_passthrough();
    test_load_use();
    test_no_hazard();
    test_back_to_back();
    test_flush_hazard();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between the decode stage (instruction decoder plus register file) and the execute stage.
- Latches the decoder's control bundle, operands, immediate and register specifiers every cycle.
- Detects load-use hazards, stalls fetch/decode, and inserts bubbles on hazard or branch/jump flush.
- Keeps saturating counters of hazard bubbles and flush bubbles for performance debug.

Parameters:
- DATA_W, 32, width of operand, immediate and PC paths
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_jtopc  in  1  decoder jump flag
- id_branch  in  1  decoder branch flag
- id_regwrite  in  1  decoder register-write flag
- id_regdst  in  1  decoder destination select (1 = rd)
- id_alusrc  in  1  decoder ALU-B immediate select
- id_memwrite  in  1  decoder store flag
- id_memread  in  1  decoder load flag
- id_memtoreg  in  1  decoder writeback select
- id_aluop  in  4  decoder ALU op code
- id_rdata1, id_rdata2  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_pc4  in  DATA_W  PC+4 of the decode instruction
- id_rs, id_rt, id_rd  in  5  register specifiers
- flush  in  1  branch/jump resolved taken; squash the decode instruction
- ex_jtopc, ex_branch, ex_regwrite, ex_regdst, ex_alusrc, ex_memwrite, ex_memread, ex_memtoreg  out  1 each  registered control
- ex_aluop  out  4  registered ALU op
- ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  DATA_W  registered data
- ex_rs, ex_rt, ex_rd  out  5  registered specifiers
- stall  out  1  hold the PC and the IF/ID register this cycle (combinational)
- hazard_cnt  out  CNT_W  load-use bubbles inserted
- flush_cnt  out  CNT_W  flush bubbles inserted

Behaviour:
- Uses one clock. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: all ex_* outputs are 0 (this is a NOOP: aluop 4'b0000, no write, no memory access). Both counters are 0. Reset has the highest priority, including mid-stall and mid-flush.
- rt_used = id_regdst | id_memwrite | id_branch.
- hazard = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (rt_used & (ex_rt == id_rt))).
- stall = hazard & ~flush. A squashed instruction is never stalled. stall is 0 during reset.
- Per-edge priority (after reset):
  - flush = 1: load a bubble (all control outputs 0, aluop 0). flush_cnt increments.
  - else hazard = 1: load a bubble. hazard_cnt increments. Upstream holds, so the same decode instruction is re-presented next cycle.
  - else: load all id_* inputs into the matching ex_* outputs. Latency is 1 cycle.
- Bubble data fields (rdata, imm, pc4, rs, rt, rd) are 0, so the execute stage never forwards from a bubble.
- A load followed by a dependent instruction gives exactly 1 bubble. The hazard clears the next cycle because ex_memread is then 0.
- Back-to-back loads where the second depends on the first: 1 bubble, then the second load issues normally.
- Counters saturate at all-ones and never wrap.
- flush and hazard in the same cycle: one bubble; only flush_cnt increments.
- There are no handshakes beyond stall and flush; the block is always ready.

Test Plan:
- Reset held 2 cycles with arbitrary id_* inputs -> all ex_* = 0, stall = 0, both counters = 0 after the edge.
- add r3,r1,r2 (regwrite=1, regdst=1, aluop=0001, rs=1, rt=2, rd=3, rdata1=5, rdata2=7) -> next cycle ex_regwrite=1, ex_aluop=0001, ex_rdata1=5, ex_rdata2=7, ex_rd=3.
- lw r4 (memread=1, rt=4) followed by add with rs=4 -> stall=1 for one cycle, a bubble in EX, hazard_cnt=1; the add appears in EX on the following edge.
- lw r4 followed by lw with rs=0, rt=4 (rt_used=0) -> stall=0, no bubble; lw rt=0 followed by add with rs=0 -> stall=0.
- flush=1 coinciding with a load-use hazard -> stall=0, bubble inserted, flush_cnt=1, hazard_cnt unchanged.
- Preload a counter to 16'hFFFE, then force 3 hazards -> counter reads 16'hFFFF and stays there; reset asserted mid-stall -> counter returns to 0 and all ex_* = 0.
